// File: rtl/fp_pkg.sv
// Shared constants and stage-register layout for the single-precision
// multiplier normalise/round stage.
package fp_pkg;

  localparam int FP_BIAS      = 127;
  localparam int FP_EXP_MAX   = 255;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int FRAC_W = 23;
  // Width of the two's-complement exponent-sum input; stage registers carry one extra bit.
  localparam int EXP_W  = 10;
  // Results whose final exponent is <= 0 always flush to signed zero.
  localparam bit FLUSH_DENORM = 1'b1;

  // Stage-1 register: normalised but not yet rounded operand.
  typedef struct packed {
    logic              sign;
    logic [EXP_W:0]    exp;
    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
    logic              zero;
    logic              inf;
    logic              nan;
  } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a 23-bit fraction using guard and sticky bits.
// A carry out of the fraction leaves frac at zero and bumps the exponent.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  input  logic [EXP_W:0]    exp,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic [EXP_W:0]    exp_rnd,
  output logic              inexact
);

  logic              round_up;
  logic [FRAC_W:0]   sum;

  // Round up above halfway, or at exactly halfway when the lsb is odd.
  assign round_up = guard & (sticky | frac[0]);
  assign sum      = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
  // On carry-out sum[FRAC_W-1:0] is already all zeros.
  assign frac_rnd = sum[FRAC_W-1:0];
  assign exp_rnd  = exp + {{EXP_W{1'b0}}, sum[FRAC_W]};
  assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_mul_normalize.sv
// Two-stage normalise / round / pack stage for the single-precision multiplier.
// Stage 1 normalises the 48-bit product; stage 2 rounds RNE, resolves
// special operands and range, and registers the packed result with flags.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// clock edge. Stage 2 loads when empty or out_ready=1; stage 1 loads when
// empty or stage 2 loads; in_ready mirrors the stage-1 load condition and
// never looks at in_valid. Outputs hold while out_valid=1 and out_ready=0.
module fp_mul_normalize
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [47:0]      in_prod,
  input  logic             in_zero,
  input  logic             in_inf,
  input  logic             in_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);

  localparam logic signed [EXP_W:0] EXP_MAX_S = (EXP_W+1)'(FP_EXP_MAX);

  s1_t  s1_d, s1_q;
  logic s1_valid;
  logic s1_load, s2_load;

  logic [FRAC_W-1:0] frac_rnd;
  logic [EXP_W:0]    exp_rnd;
  logic              rnd_inexact;
  logic signed [EXP_W:0] exp_s;

  logic [31:0] res_d;
  logic        ovf_d, unf_d, inx_d;

  assign s2_load  = !out_valid | out_ready;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = s1_load;

  // Normalise: pick the fraction window by the product's leading bit.
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.zero   = in_zero;
    s1_d.inf    = in_inf;
    s1_d.nan    = in_nan;
    s1_d.exp    = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, in_prod[47]};
    if (in_prod[47]) begin
      s1_d.frac   = in_prod[46:24];
      s1_d.guard  = in_prod[23];
      s1_d.sticky = |in_prod[22:0];
    end else begin
      s1_d.frac   = in_prod[45:23];
      s1_d.guard  = in_prod[22];
      s1_d.sticky = |in_prod[21:0];
    end
  end

  // Stage-1 register: accepts a new beat whenever it can hand its current one on.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  fp_round_rne u_round (
    .frac     (s1_q.frac),
    .guard    (s1_q.guard),
    .sticky   (s1_q.sticky),
    .exp      (s1_q.exp),
    .frac_rnd (frac_rnd),
    .exp_rnd  (exp_rnd),
    .inexact  (rnd_inexact)
  );

  assign exp_s = $signed(exp_rnd);

  // Pack: specials first (flags cleared), then overflow, flush-to-zero, normal.
  always_comb begin
    res_d = {s1_q.sign, exp_rnd[7:0], frac_rnd};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = rnd_inexact;
    if (s1_q.nan || (s1_q.inf && s1_q.zero)) begin
      res_d = FP_QNAN;
      inx_d = 1'b0;
    end else if (s1_q.inf) begin
      res_d = {s1_q.sign, 8'hFF, 23'd0};
      inx_d = 1'b0;
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, 31'd0};
      inx_d = 1'b0;
    end else if (exp_s >= EXP_MAX_S) begin
      res_d = {s1_q.sign, 8'hFF, 23'd0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_s <= 0) begin
      res_d = {s1_q.sign, 31'd0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  // Stage-2 / output register: only updates when the consumer can take a new result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_d;
        out_overflow  <= ovf_d;
        out_underflow <= unf_d;
        out_inexact   <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed bench for fp_mul_normalize: table of hand-computed vectors,
// then backpressure and mid-stream reset sequences.
module tb_fp_mul_normalize;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] prod;
    logic        zero;
    logic        inf;
    logic        nan;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } vec_t;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [34:0] exp_q[$];
  vec_t vecs[$];

  fp_mul_normalize dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_prod       (in_prod),
    .in_zero       (in_zero),
    .in_inf        (in_inf),
    .in_nan        (in_nan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [47:0] p,
                              input logic z, input logic i, input logic n,
                              input logic [31:0] r, input logic o, input logic u, input logic x);
    vec_t v;
    v.sign = s; v.exp = e; v.prod = p; v.zero = z; v.inf = i; v.nan = n;
    v.res = r; v.ovf = o; v.unf = u; v.inx = x;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Presents one beat, pushes its expectation when it will be accepted, returns #1 after the accepting edge.
  task automatic send(input vec_t v);
    int  cnt;
    logic acc;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_prod  = v.prod;
    in_zero  = v.zero;
    in_inf   = v.inf;
    in_nan   = v.nan;
    in_valid = 1'b1;
    cnt = 0;
    acc = 1'b0;
    while (!acc && cnt < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({v.res, v.ovf, v.unf, v.inx});
      @(posedge clk);
      #1;
      cnt++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", out_result);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        n_out++;
        chk("result", out_result, e[34:3]);
        chk("flags", {29'd0, out_overflow, out_underflow, out_inexact}, {29'd0, e[2:0]});
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    int   outs_before;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    in_zero   = 1'b0;
    in_inf    = 1'b0;
    in_nan    = 1'b0;
    out_ready = 1'b1;

    //         sign exp      prod              z  i  n  result         o  u  x
    vecs.push_back(mk(0, 10'd127, 48'h780000000000, 0, 0, 0, 32'h3FF00000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd129, 48'h600000000000, 0, 0, 0, 32'h40C00000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd127, 48'h900000000000, 0, 0, 0, 32'h40100000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd127, 48'h600000000000, 0, 0, 0, 32'hBFC00000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 0, 0, 1));
    vecs.push_back(mk(0, 10'd127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 0, 0, 1));
    vecs.push_back(mk(0, 10'd127, 48'h400000000001, 0, 0, 0, 32'h3F800000, 0, 0, 1));
    vecs.push_back(mk(0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 0, 0, 1));
    vecs.push_back(mk(0, 10'd254, 48'h400000000000, 0, 0, 0, 32'h7F000000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd254, 48'hC00000000000, 0, 0, 0, 32'h7F800000, 1, 0, 1));
    vecs.push_back(mk(0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 1, 0, 1));
    vecs.push_back(mk(1, 10'd383, 48'h400000000000, 0, 0, 0, 32'hFF800000, 1, 0, 1));
    vecs.push_back(mk(0, 10'd1,   48'h400000000000, 0, 0, 0, 32'h00800000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd0,   48'h400000000000, 0, 0, 0, 32'h80000000, 0, 1, 1));
    vecs.push_back(mk(1, 10'h3FB, 48'h400000000000, 0, 0, 0, 32'h80000000, 0, 1, 1));
    vecs.push_back(mk(0, 10'h381, 48'h800000000000, 0, 0, 0, 32'h00000000, 0, 1, 1));
    vecs.push_back(mk(1, 10'd127, 48'h400000000000, 1, 1, 0, 32'h7FC00000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd254, 48'hC00000000000, 0, 1, 0, 32'hFF800000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd127, 48'h400000C00000, 1, 0, 0, 32'h80000000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd0,   48'h400000000000, 1, 0, 0, 32'h00000000, 0, 0, 0));
    vecs.push_back(mk(0, 10'd127, 48'h780000000000, 0, 0, 1, 32'h7FC00000, 0, 0, 0));
    vecs.push_back(mk(1, 10'd254, 48'hC00000000000, 0, 1, 1, 32'h7FC00000, 0, 0, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: one beat at a time, two-cycle latency checked per vector.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i]);
      chk("latency_cycle1_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("latency_cycle2_valid", {31'd0, out_valid}, 32'd1);
    end
    drain("table_drain");

    // Backpressure: three back-to-back beats with out_ready low for 4 cycles.
    outs_before = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(vecs[0]);
        send(vecs[4]);
        send(vecs[9]);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #2;
          chk("bp_hold_result", out_result, 32'h3FF00000);
          chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_output_count", n_out - outs_before, 3);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream: in-flight beats vanish.
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_result", out_result, 32'd0);
    exp_q.delete();
    outs_before = n_out;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_output", n_out - outs_before, 0);
    chk("midrst_idle_valid", {31'd0, out_valid}, 32'd0);

    // Recovery after reset.
    send(vecs[3]);
    drain("recover_drain");
    chk("recover_count", n_out - outs_before, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_normalize.md
Name: fp_mul_normalize

Overview:
Downstream normalise/round stage for the single-precision multiplier datapath. It consumes the raw sign, biased exponent sum and 48-bit significand product, then normalises and rounds round-to-nearest-even. It handles special-operand cases and packs an IEEE-754 single result with status flags. It is a 2-stage valid/ready pipeline that sits between the multiplier core and the result writeback.

Parameters:
EXP_W, 10, width of the two's-complement exponent-sum input
FLUSH_DENORM, 1, results with final exponent <= 0 flush to signed zero (only value supported)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept input
in_sign  in  1  result sign (op1 sign XOR op2 sign)
in_exp  in  EXP_W  signed e1+e2-127, legal range -127..383
in_prod  in  48  {1,m1} * {1,m2}
in_zero  in  1  either operand is zero
in_inf  in  1  either operand is infinity
in_nan  in  1  either operand is NaN
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  32  packed single-precision result
out_overflow  out  1  result overflowed to infinity
out_underflow  out  1  result flushed to zero
out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low. Reset clears both stage valids, out_result and all flags to 0, so in_ready=1 after reset.
- Reset mid-operation: in-flight beats are dropped with no output.
- Handshake: a beat transfers when valid and ready are both high at the clock edge.
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid | s2_load (combinational, no dependency on in_valid).
  - Latency is 2 cycles with out_ready=1; throughput is 1 per cycle.
- Output stability: out_result and flags hold stable while out_valid=1 and out_ready=0.
- Stage 1, normalise:
  - If in_prod[47]=1: frac=prod[46:24], G=prod[23], S=|prod[22:0], exp=in_exp+1.
  - Else: frac=prod[45:23], G=prod[22], S=|prod[21:0], exp=in_exp.
  - Register sign, exp (EXP_W+1 bits), frac, G, S and the special flags.
- Stage 2, round and pack:
  - round_up = G & (S | frac[0]).
  - frac+round_up carrying out of 23 bits gives frac=0 and exp+1.
  - inexact = G|S.
  - exp >= 255 gives {sign,8'hFF,0}, overflow=1, inexact=1.
  - exp <= 0 gives {sign,31'b0}, underflow=1, inexact=1.
  - Otherwise the result is {sign,exp[7:0],frac}.
- Special-case priority (specials force overflow/underflow/inexact to 0):
  1. in_nan, or in_inf & in_zero: 32'h7FC00000.
  2. in_inf: {sign,8'hFF,0}.
  3. in_zero: {sign,31'b0}.
- Flags are valid only with out_valid. They are held with the result and not sticky across beats.

Decomposition:
- Shared package fp_pkg holds:
  - FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000
  - FRAC_W=23, EXP_W
  - the typedef struct packed for the stage-1 register (sign, exp, frac, guard, sticky, zero, inf, nan)
- One combinational sub-module, fp_round_rne: takes frac, guard, sticky and exp, and returns rounded frac, adjusted exp and inexact.

Test Plan:
- 1.25*1.5: sign=0, exp=127, prod=48'h780000000000 -> after 2 cycles out_result=32'h3FF00000, all flags 0.
- 2.0*3.0: exp=129, prod=48'h600000000000 -> 32'h40C00000. 1.5*1.5: exp=127, prod=48'h900000000000 -> 32'h40100000.
- RNE:
  - prod=48'h400000C00000, exp=127 -> 32'h3F800002, inexact=1.
  - prod=48'h400000400000 (tie, lsb 0) -> 32'h3F800000, inexact=1.
- Range:
  - exp=254, prod=48'hC00000000000 -> 32'h7F800000, overflow=1.
  - exp=0, prod=48'h400000000000, sign=1 -> 32'h80000000, underflow=1.
- Specials:
  - in_inf&in_zero -> 32'h7FC00000.
  - in_inf with sign=1 -> 32'hFF800000.
  - in_zero -> signed zero, all flags 0.
- Backpressure: issue 3 back-to-back beats, hold out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, out_result stable. On release the results appear in order, none lost or duplicated. Assert n_rst mid-stream -> out_valid=0 immediately.
